// File: rtl/sample_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_bank_pkg : bank-state encoding and drop-counter width          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sample_bank_pkg;

    localparam int c_DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } bank_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_bank_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_bank_mem : NUM_BANKS x DEPTH sample store, registered read     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sample_bank_mem
    import sample_bank_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [BANK_W-1:0] i_wr_bank,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [BANK_W-1:0] i_rd_bank,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_BANKS][2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Array has no reset so it can map onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_bank][i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sample_bank_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sample_bank_ctrl : multi-bank ping-pong sample buffer for a DSP       |
// | Optional drop counter: define SAMPLE_BANK_DROP_CNT_EN. Rev 1.0        |
// +----------------------------------------------------------------------+
module sample_bank_ctrl
    import sample_bank_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int ADDR_W    = 10,
    parameter  int NUM_BANKS = 2,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    rd_valid,
    output logic [BANK_W-1:0]       rd_bank,
    input  logic                    dsp_rd_en,
    input  logic [ADDR_W-1:0]       dsp_addr,
    output logic [DATA_W-1:0]       dsp_rdata,
    input  logic                    dsp_release,
    output logic [BANK_W:0]         full_cnt,
    output logic [c_DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [BANK_W-1:0] c_LAST_BANK = BANK_W'(NUM_BANKS - 1);

    bank_state_t       r_state     [NUM_BANKS];
    bank_state_t       w_state_nxt [NUM_BANKS];
    logic [BANK_W-1:0] r_wr_ptr;
    logic [BANK_W-1:0] r_rd_ptr;
    logic [BANK_W-1:0] w_wr_ptr_nxt;
    logic [BANK_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_in_ready;
    logic              r_rd_valid;
    logic [BANK_W:0]   r_full_cnt;
    logic [BANK_W:0]   w_full_cnt_nxt;
    logic              w_accept;
    logic              w_release;
    logic              w_fill_done;

    assign w_accept    = in_valid & r_in_ready;
    assign w_release   = dsp_release & r_rd_valid;
    assign w_fill_done = w_accept & (&r_wr_addr);

    assign w_wr_ptr_nxt = !w_fill_done ? r_wr_ptr :
                          (r_wr_ptr == c_LAST_BANK) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = !w_release ? r_rd_ptr :
                          (r_rd_ptr == c_LAST_BANK) ? '0 : r_rd_ptr + 1'b1;

    // The filling bank is never READY and the released bank always is, so the two updates never collide.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_state_nxt[b] = r_state[b];
        end
        if (w_accept) begin
            w_state_nxt[r_wr_ptr] = w_fill_done ? READY : FILLING;
        end
        if (w_release) begin
            w_state_nxt[r_rd_ptr] = FREE;
        end
    end

    always_comb begin
        w_full_cnt_nxt = r_full_cnt;
        if (w_fill_done && !w_release) begin
            w_full_cnt_nxt = r_full_cnt + 1'b1;
        end else if (!w_fill_done && w_release) begin
            w_full_cnt_nxt = r_full_cnt - 1'b1;
        end
    end

    // Handshake flags are registered from next state, so a release frees the writer one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b] <= FREE;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_addr  <= '0;
            r_in_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_full_cnt <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_state[b] <= w_state_nxt[b];
            end
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            if (w_accept) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            r_in_ready <= (w_state_nxt[w_wr_ptr_nxt] != READY);
            r_rd_valid <= (w_state_nxt[w_rd_ptr_nxt] == READY);
            r_full_cnt <= w_full_cnt_nxt;
        end
    end

    sample_bank_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_BANKS (NUM_BANKS),
        .BANK_W    (BANK_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_accept),
        .i_wr_bank (r_wr_ptr),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (in_data),
        .i_rd_en   (dsp_rd_en & r_rd_valid),
        .i_rd_bank (r_rd_ptr),
        .i_rd_addr (dsp_addr),
        .o_rd_data (dsp_rdata)
    );

`ifdef SAMPLE_BANK_DROP_CNT_EN
    logic                    w_drop;
    logic [c_DROP_CNT_W-1:0] r_drop_cnt;

    assign w_drop = in_valid & ~r_in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && !(&r_drop_cnt)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    assign in_ready = r_in_ready;
    assign rd_valid = r_rd_valid;
    assign rd_bank  = r_rd_ptr;
    assign full_cnt = r_full_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sample_bank_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sample_bank_ctrl : directed vector bench, ADDR_W=2 NUM_BANKS=2     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sample_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        rd_valid;
    logic [0:0]  rd_bank;
    logic        dsp_rd_en;
    logic [1:0]  dsp_addr;
    logic [15:0] dsp_rdata;
    logic        dsp_release;
    logic [1:0]  full_cnt;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sample_bank_ctrl #(
        .DATA_W    (16),
        .ADDR_W    (2),
        .NUM_BANKS (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .rd_valid    (rd_valid),
        .rd_bank     (rd_bank),
        .dsp_rd_en   (dsp_rd_en),
        .dsp_addr    (dsp_addr),
        .dsp_rdata   (dsp_rdata),
        .dsp_release (dsp_release),
        .full_cnt    (full_cnt),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [15:0] din;
        logic        rd;
        logic [1:0]  addr;
        logic        rel;
        logic        rdy;
        logic        rv;
        logic        rb;
        logic [1:0]  fc;
        logic [15:0] rdata;
        logic [15:0] drops;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic v, input int d, input logic rd,
                                input int a, input logic rel, input logic rdy, input logic rv,
                                input logic rb, input int fc, input int rdata, input int drops);
        vec_t t;
        t.rst_n = r;   t.vld = v;     t.din = 16'(d);  t.rd = rd;
        t.addr  = 2'(a); t.rel = rel; t.rdy = rdy;     t.rv = rv;
        t.rb    = rb;  t.fc = 2'(fc); t.rdata = 16'(rdata); t.drops = 16'(drops);
        return t;
    endfunction

    function automatic int exp_drop(input int d);
`ifdef SAMPLE_BANK_DROP_CNT_EN
        return d;
`else
        return 0 * d;
`endif
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input int d, input logic rd,
                         input int a, input logic rel);
        rst_n       = r;
        in_valid    = v;
        in_data     = 16'(d);
        dsp_rd_en   = rd;
        dsp_addr    = 2'(a);
        dsp_release = rel;
        @(negedge clk);
    endtask

    task automatic check_outs(input int idx, input logic rdy, input logic rv, input logic rb,
                              input int fc, input int rdata, input int drops);
        chk("in_ready",  idx, 32'(in_ready),  32'(rdy));
        chk("rd_valid",  idx, 32'(rd_valid),  32'(rv));
        chk("rd_bank",   idx, 32'(rd_bank),   32'(rb));
        chk("full_cnt",  idx, 32'(full_cnt),  32'(fc));
        chk("dsp_rdata", idx, 32'(dsp_rdata), 32'(rdata));
        chk("drop_cnt",  idx, 32'(drop_cnt),  32'(exp_drop(drops)));
    endtask

    initial begin
        int drops;
        //              rst v  din rd a rel | rdy rv rb fc rdata drops
        vq.push_back(mk(0, 0,  0, 0, 0, 0,   0, 0, 0, 0,  0, 0));  // 0 reset
        vq.push_back(mk(1, 0,  0, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  1, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  2, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  3, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  4, 0, 0, 0,   1, 1, 0, 1,  0, 0));  // 5 bank 0 full
        vq.push_back(mk(1, 1,  5, 1, 0, 0,   1, 1, 0, 1,  1, 0));
        vq.push_back(mk(1, 1,  6, 1, 1, 0,   1, 1, 0, 1,  2, 0));
        vq.push_back(mk(1, 1,  7, 1, 2, 0,   1, 1, 0, 1,  3, 0));
        vq.push_back(mk(1, 1,  8, 1, 3, 0,   0, 1, 0, 2,  4, 0));  // 9 both full
        vq.push_back(mk(1, 1,  9, 0, 0, 0,   0, 1, 0, 2,  4, 1));  // sample 9 dropped
        vq.push_back(mk(1, 1, 10, 0, 0, 1,   1, 1, 1, 1,  4, 2));  // release + dropped sample
        vq.push_back(mk(1, 1, 11, 0, 0, 0,   1, 1, 1, 1,  4, 2));
        vq.push_back(mk(1, 1, 12, 1, 0, 0,   1, 1, 1, 1,  5, 2));
        vq.push_back(mk(1, 1, 13, 1, 3, 0,   1, 1, 1, 1,  8, 2));
        vq.push_back(mk(1, 1, 14, 0, 0, 1,   1, 1, 0, 1,  8, 2));  // 15 fill + release
        vq.push_back(mk(1, 1, 15, 0, 0, 0,   1, 1, 0, 1,  8, 2));
        vq.push_back(mk(1, 1, 16, 0, 0, 0,   1, 1, 0, 1,  8, 2));
        vq.push_back(mk(0, 1, 77, 1, 1, 1,   0, 0, 0, 0,  0, 0));  // 18 reset mid-fill
        vq.push_back(mk(1, 0,  0, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  5, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  6, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  7, 0, 0, 0,   1, 0, 0, 0,  0, 0));
        vq.push_back(mk(1, 1,  8, 0, 0, 0,   1, 1, 0, 1,  0, 0));
        vq.push_back(mk(1, 1, 20, 1, 0, 0,   1, 1, 0, 1,  5, 0));
        vq.push_back(mk(1, 1, 21, 1, 1, 0,   1, 1, 0, 1,  6, 0));
        vq.push_back(mk(1, 1, 22, 1, 2, 0,   1, 1, 0, 1,  7, 0));
        vq.push_back(mk(1, 1, 23, 1, 3, 1,   1, 1, 1, 1,  8, 0));  // 27 bank1 fill + bank0 release
        vq.push_back(mk(1, 0,  0, 0, 0, 1,   1, 0, 0, 0,  8, 0));
        vq.push_back(mk(1, 0,  0, 1, 1, 1,   1, 0, 0, 0,  8, 0));  // 29 ignored while rd_valid=0
        vq.push_back(mk(1, 1, 30, 0, 0, 0,   1, 0, 0, 0,  8, 0));
        vq.push_back(mk(1, 1, 31, 0, 0, 0,   1, 0, 0, 0,  8, 0));
        vq.push_back(mk(1, 1, 32, 0, 0, 0,   1, 0, 0, 0,  8, 0));
        vq.push_back(mk(1, 1, 33, 0, 0, 0,   1, 1, 0, 1,  8, 0));  // 33 proves wr_ptr was 0
        vq.push_back(mk(1, 0,  0, 1, 2, 0,   1, 1, 0, 1, 32, 0));

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        dsp_rd_en = 1'b0; dsp_addr = '0; dsp_release = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst_n, vq[i].vld, 32'(vq[i].din), vq[i].rd, 32'(vq[i].addr), vq[i].rel);
            check_outs(i, vq[i].rdy, vq[i].rv, vq[i].rb, 32'(vq[i].fc), 32'(vq[i].rdata),
                       32'(vq[i].drops));
        end

        // Fill bank 1 so every bank is READY, then hammer in_valid while stalled.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 40 + k, 0, 0, 0);
        end
        check_outs(100, 0, 1, 0, 2, 32, 0);
        drops = 0;
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 50 + k, 0, 0, 0);
            drops++;
            check_outs(101 + k, 0, 1, 0, 2, 32, drops);
        end
        drive(1, 1, 60, 0, 0, 1);
        drops++;
        check_outs(110, 1, 1, 1, 1, 32, drops);
        drive(1, 0, 0, 1, 3, 0);
        check_outs(111, 1, 1, 1, 1, 43, drops);
        drive(1, 0, 0, 1, 0, 0);
        check_outs(112, 1, 1, 1, 1, 40, drops);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_bank_ctrl.md
SAMPLE_BANK_CTRL -- requirements
Module: sample_bank_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, sample and read-data width in bits.
REQ-002 Parameter ADDR_W, default 10, per-bank address width; bank depth DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_BANKS, default 2, bank count, legal range 2..8; BANK_W = clog2(NUM_BANKS).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  input sample strobe from the front end.
REQ-007 in_data  in  DATA_W  input sample.
REQ-008 in_ready  out  1  sample is accepted this cycle if in_valid=1.
REQ-009 rd_valid  out  1  the oldest full bank is available to the DSP.
REQ-010 rd_bank  out  BANK_W  index of the bank currently offered to the DSP.
REQ-011 dsp_rd_en  in  1  read strobe.
REQ-012 dsp_addr  in  ADDR_W  read address within the offered bank.
REQ-013 dsp_rdata  out  DATA_W  read data.
REQ-014 dsp_release  in  1  DSP is finished with the offered bank.
REQ-015 full_cnt  out  BANK_W+1  number of banks in state READY.
REQ-016 drop_cnt  out  16  count of dropped samples (see Configuration).

Function
REQ-017 Each bank SHALL hold one state: FREE, FILLING, or READY. READY banks are queued for the DSP in fill order.
REQ-018 The writer SHALL fill bank wr_ptr at addresses 0..DEPTH-1 in order, one accepted sample per cycle.
REQ-019 A sample is accepted only when in_valid=1 and in_ready=1.
REQ-020 in_ready SHALL be 1 only when bank wr_ptr is FREE or FILLING.
REQ-021 The source does not stall: a sample presented with in_valid=1 and in_ready=0 SHALL be discarded.
REQ-022 On the write to address DEPTH-1, in the same edge: bank wr_ptr SHALL become READY, wr_ptr SHALL advance modulo NUM_BANKS, and the write address SHALL return to 0.
REQ-023 rd_valid SHALL be 1 when bank rd_ptr is READY; rd_bank SHALL equal rd_ptr.
REQ-024 When dsp_rd_en=1 and rd_valid=1, dsp_rdata SHALL present mem[rd_ptr][dsp_addr] exactly one cycle later.
REQ-025 In every other case dsp_rdata SHALL hold its previous value.
REQ-026 When dsp_release=1 and rd_valid=1, bank rd_ptr SHALL become FREE and rd_ptr SHALL advance modulo NUM_BANKS.
REQ-027 dsp_release=1 while rd_valid=0 SHALL be ignored.
REQ-028 Release of bank k and completion of a fill in the same cycle SHALL both take effect. A writer stalled on bank k SHALL see in_ready=1 on the following cycle, not the same cycle.
REQ-029 full_cnt SHALL equal the number of READY banks after each edge, including simultaneous fill-complete and release.
REQ-030 All banks READY SHALL hold in_ready=0 until a release occurs.

Reset
REQ-031 While rst_n=0 at an edge: all banks FREE, wr_ptr=0, rd_ptr=0, write address=0, in_ready=0, rd_valid=0, rd_bank=0, dsp_rdata=0, full_cnt=0, drop_cnt=0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n returns to 1.
REQ-033 Reset mid-fill or mid-read SHALL discard all bank contents logically. Memory arrays are not cleared.

Configuration
REQ-034 With SAMPLE_BANK_DROP_CNT_EN defined, drop_cnt SHALL increment by 1 for each discarded sample (REQ-021) and saturate at 16'hFFFF.
REQ-035 Without SAMPLE_BANK_DROP_CNT_EN, drop_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-036 A shared package sample_bank_pkg SHALL hold the bank-state enum (FREE, FILLING, READY) and the drop-counter width constant.
REQ-037 Storage SHALL be one sub-module, sample_bank_mem: NUM_BANKS x DEPTH x DATA_W, one write port and one registered read port.

Verification (ADDR_W=2, NUM_BANKS=2, DATA_W=16)
REQ-038 Reset followed by samples 1..4 -> after the 4th accepted edge, rd_valid=1, rd_bank=0, full_cnt=1; reading addresses 0..3 returns 1,2,3,4 with 1-cycle latency.
REQ-039 Samples 1..8 with no release, then sample 9 -> in_ready=0 after the 8th; sample 9 dropped; drop_cnt=1 (macro on) or 0 (macro off); full_cnt=2.
REQ-040 Both banks full, release asserted on the same cycle as a sample -> that sample dropped; next cycle in_ready=1; rd_bank=1; full_cnt=1.
REQ-041 Bank 1 fill completes in the same cycle as bank 0 release -> full_cnt stays 1, rd_bank=1, wr_ptr=0.
REQ-042 rst_n low after 2 of 4 samples -> all outputs at reset values. Afterwards, 4 new samples 5..8 read back as 5,6,7,8 from bank 0.
REQ-043 dsp_release or dsp_rd_en with rd_valid=0 -> no state change; dsp_rdata unchanged.
